// File: rtl/adder_op_sequencer_if.sv
// Operand/result bundle between the GPIO block, the sequencer and the ripple adder.
interface adder_op_sequencer_if #(
   parameter int CNT_W = 8
);
   logic [15:0]      op_word_i;
   logic [7:0]       a_o;
   logic [7:0]       b_o;
   logic [7:0]       sum_i;
   logic             cout_i;
   logic [8:0]       result_o;
   logic             done_o;
   logic             busy_o;
   logic [CNT_W-1:0] op_count_o;

   // Environment side: GPIO word and adder return path.
   modport master (
      output op_word_i, sum_i, cout_i,
      input  a_o, b_o, result_o, done_o, busy_o, op_count_o
   );

   // Sequencer side.
   modport slave (
      input  op_word_i, sum_i, cout_i,
      output a_o, b_o, result_o, done_o, busy_o, op_count_o
   );
endinterface

// File: rtl/adder_op_sequencer.sv
// Waits for the GPIO operand word to settle, launches it to the ripple adder,
// holds it for the evaluation window and captures {carry, sum} with a done pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | launched operands match op_q, waiting for a new word
// SETTLE  | candidate word must stay unchanged for SETTLE_CYC cycles
// EVAL    | operands held at the adder for EVAL_CYC cycles
// CAPTURE | one cycle: latch adder result, pulse done, bump op counter
module adder_op_sequencer #(
   parameter int SETTLE_CYC = 4,
   parameter int EVAL_CYC   = 2,
   parameter int CNT_W      = 8
) (
   input logic                 clk,
   input logic                 rst,
   adder_op_sequencer_if.slave bus
);

   localparam int CMAX = (SETTLE_CYC > EVAL_CYC) ? SETTLE_CYC : EVAL_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] EVAL_TC   = CW'(EVAL_CYC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      EVAL    = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t        state;
   logic [15:0]   op_q;
   logic [15:0]   cand;
   logic [CW-1:0] cnt;

   // Single sampling point for the asynchronously written GPIO word.
   always_ff @(posedge clk) begin
      if (rst) op_q <= 16'h0000;
      else     op_q <= bus.op_word_i;
   end

   // Sequencing FSM with registered operand, result and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         cand           <= 16'h0000;
         bus.a_o        <= 8'h00;
         bus.b_o        <= 8'h00;
         bus.result_o   <= 9'h000;
         bus.done_o     <= 1'b0;
         bus.op_count_o <= '0;
      end else begin
         bus.done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (op_q != {bus.b_o, bus.a_o}) begin
                  cand  <= op_q;
                  cnt   <= '0;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               if (op_q != cand) begin
                  cand <= op_q;
                  cnt  <= '0;
               end else if (cnt == SETTLE_TC) begin
                  bus.a_o <= cand[7:0];
                  bus.b_o <= cand[15:8];
                  cnt     <= '0;
                  state   <= EVAL;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EVAL: begin
               if (cnt == EVAL_TC) state <= CAPTURE;
               else                cnt   <= cnt + 1'b1;
            end
            CAPTURE: begin
               // Carry comes straight from the adder; no local re-add.
               bus.result_o   <= {bus.cout_i, bus.sum_i};
               bus.done_o     <= 1'b1;
               bus.op_count_o <= bus.op_count_o + CNT_W'(1);
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Busy is a pure decode of the state register.
   assign bus.busy_o = (state != IDLE);

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Self-checking bench for adder_op_sequencer with a behavioural adder model.
module tb_adder_op_sequencer;

   localparam int SETTLE = 4;
   localparam int EVAL   = 2;
   localparam int LAT    = 3 + SETTLE + EVAL;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   adder_op_sequencer_if #(.CNT_W(8)) bus ();

   // Ideal 8-bit adder closing the combinational return path.
   assign {bus.cout_i, bus.sum_i} = {1'b0, bus.a_o} + {1'b0, bus.b_o};

   adder_op_sequencer #(
      .SETTLE_CYC(SETTLE),
      .EVAL_CYC  (EVAL),
      .CNT_W     (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;
   int done_seen = 0;
   int busy_seen = 0;

   always @(negedge clk) begin
      if (bus.done_o === 1'b1) done_seen++;
      if (bus.busy_o === 1'b1) busy_seen++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] word;
      logic [8:0]  res;
   } vec_t;

   vec_t vecs [3];

   int          exp_cnt;
   logic [15:0] launched;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edges until done_o is seen, -1 on timeout.
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (bus.done_o === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [15:0] w, output int lat);
      bus.op_word_i = w;
      wait_done(lat);
   endtask

   // Checks expected after a completed operation on word w.
   task automatic check_op(input string tag, input logic [15:0] w, input int lat);
      logic [8:0] exp_res;
      exp_res = 9'(w[7:0]) + 9'(w[15:8]);
      exp_cnt = (exp_cnt + 1) % 256;
      launched = w;
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_result"}, 32'(bus.result_o), 32'(exp_res));
      check({tag, "_a"}, 32'(bus.a_o), 32'(w[7:0]));
      check({tag, "_b"}, 32'(bus.b_o), 32'(w[15:8]));
      check({tag, "_count"}, 32'(bus.op_count_o), 32'(exp_cnt));
      check({tag, "_busy_at_done"}, 32'(bus.busy_o), 0);
      tick();
      check({tag, "_done_width"}, 32'(bus.done_o), 0);
   endtask

   initial begin
      int lat;
      int base_d;
      int base_b;
      logic [15:0] fin;
      logic [15:0] gv;
      logic [15:0] prev;
      int ng;
      int k;

      vecs[0] = '{word: 16'h0503, res: 9'h008};
      vecs[1] = '{word: 16'hFFFF, res: 9'h1FE};
      vecs[2] = '{word: 16'h0180, res: 9'h081};

      exp_cnt  = 0;
      launched = 16'h0000;

      // Reset state
      bus.op_word_i = 16'h0000;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("rst_busy", 32'(bus.busy_o), 0);
      check("rst_result", 32'(bus.result_o), 0);
      check("rst_count", 32'(bus.op_count_o), 0);
      check("rst_ab", {16'h0, bus.b_o, bus.a_o}, 0);
      check("rst_done", 32'(bus.done_o), 0);
      base_d = done_seen;
      base_b = busy_seen;
      repeat (50) tick();
      check("idle_no_done", done_seen - base_d, 0);
      check("idle_no_busy", busy_seen - base_b, 0);

      // Table-driven operations
      for (int i = 0; i < 3; i++) begin
         run_op(vecs[i].word, lat);
         check($sformatf("vec%0d_table_result", i), 32'(bus.result_o), 32'(vecs[i].res));
         check_op($sformatf("vec%0d", i), vecs[i].word, lat);
      end

      // Glitchy write: short-lived word must not launch
      base_d = done_seen;
      bus.op_word_i = 16'h0001;
      repeat (2) tick();
      run_op(16'h0202, lat);
      check("glitch_result_const", 32'(bus.result_o), 32'h004);
      check_op("glitch", 16'h0202, lat);
      repeat (20) tick();
      check("glitch_one_done", done_seen - base_d, 1);

      // Rewriting the launched word while idle launches nothing
      base_d = done_seen;
      base_b = busy_seen;
      bus.op_word_i = 16'h0202;
      repeat (30) tick();
      check("rewrite_no_done", done_seen - base_d, 0);
      check("rewrite_no_busy", busy_seen - base_b, 0);

      // Word change during EVAL: in-flight op unaffected, new one follows
      bus.op_word_i = 16'h0303;
      repeat (7) tick();
      check("eval_busy", 32'(bus.busy_o), 1);
      bus.op_word_i = 16'h0404;
      wait_done(lat);
      check("evalchg_first_lat", lat, 2);
      check("evalchg_first_res", 32'(bus.result_o), 32'h006);
      check("evalchg_first_a", 32'(bus.a_o), 32'h03);
      exp_cnt = (exp_cnt + 1) % 256;
      check("evalchg_first_cnt", 32'(bus.op_count_o), 32'(exp_cnt));
      wait_done(lat);
      check("evalchg_second_lat", lat, LAT - 1);
      check("evalchg_second_res", 32'(bus.result_o), 32'h008);
      exp_cnt = (exp_cnt + 1) % 256;
      launched = 16'h0404;
      check("evalchg_second_cnt", 32'(bus.op_count_o), 32'(exp_cnt));
      tick();

      // Randomized operations with sub-window glitches; crosses the counter wrap
      base_d = done_seen;
      for (int op = 0; op < 260; op++) begin
         fin = 16'($urandom);
         while (fin == launched) fin = 16'($urandom);
         ng = $urandom_range(0, 2);
         prev = launched;
         for (int g = 0; g < ng; g++) begin
            gv = 16'($urandom);
            while (gv == fin || gv == prev) gv = 16'($urandom);
            k = $urandom_range(1, SETTLE);
            bus.op_word_i = gv;
            repeat (k) tick();
            prev = gv;
         end
         run_op(fin, lat);
         check_op($sformatf("rand%0d", op), fin, lat);
         if (exp_cnt == 0) check("count_wrap", 32'(bus.op_count_o), 0);
      end
      check("rand_done_total", done_seen - base_d, 260);

      // Reset during EVAL aborts the operation
      bus.op_word_i = launched ^ 16'h1234;
      repeat (7) tick();
      check("abort_busy", 32'(bus.busy_o), 1);
      base_d = done_seen;
      rst = 1'b1;
      bus.op_word_i = 16'h0101;
      tick();
      check("abort_ab", {16'h0, bus.b_o, bus.a_o}, 0);
      check("abort_result", 32'(bus.result_o), 0);
      check("abort_count", 32'(bus.op_count_o), 0);
      check("abort_done", 32'(bus.done_o), 0);
      check("abort_busy_clr", 32'(bus.busy_o), 0);
      repeat (5) tick();
      check("abort_no_done", done_seen - base_d, 0);
      rst = 1'b0;
      wait_done(lat);
      check("post_rst_lat", lat, LAT);
      check("post_rst_result", 32'(bus.result_o), 32'h002);
      check("post_rst_count", 32'(bus.op_count_o), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adder_op_sequencer.md
Name: adder_op_sequencer

Overview:
- Sequential stage between the PS GPIO output word and the 8-bit ripple adder.
- Samples the 16-bit GPIO operand word and waits until it has been stable for a programmable settle window, so a half-written word is never evaluated.
- Launches the stable operands to the adder, waits a fixed evaluation window, then captures {carry, sum}.
- Presents the captured result to the GPIO input channel with a completion pulse and an operation counter.

Parameters:
- SETTLE_CYC, 4, consecutive stable cycles required before launch (minimum 1)
- EVAL_CYC, 2, cycles the operands are held at the adder before capture (minimum 1)
- CNT_W, 8, width of the completed-operation counter

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  reset, synchronous, active-high
- op_word_i  input  16  GPIO operand word: [7:0] = A, [15:8] = B
- a_o  output  8  operand A driven to adder
- b_o  output  8  operand B driven to adder
- sum_i  input  8  adder sum (combinational return)
- cout_i  input  1  adder carry-out (combinational return)
- result_o  output  9  captured {carry, sum}, to GPIO channel 2
- done_o  output  1  one-cycle pulse: result_o updated
- busy_o  output  1  high whenever state is not IDLE
- op_count_o  output  CNT_W  number of completed captures, wraps

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - op_q, cand, a_o, b_o, result_o = 0; done_o = 0; op_count_o = 0
  - State IDLE, counter = 0
- Input register: op_q <= op_word_i every cycle. This is the only sampling point; no other logic reads op_word_i.
- IDLE state:
  - If op_q != {b_o, a_o}: cand <= op_q, cnt <= 0, go to SETTLE.
  - Otherwise stay in IDLE.
  - Rewriting the same value therefore launches nothing.
- SETTLE state:
  - If op_q != cand: cand <= op_q, cnt <= 0 (restart the window).
  - Else if cnt == SETTLE_CYC-1: {b_o, a_o} <= cand, cnt <= 0, go to EVAL.
  - Else cnt <= cnt+1.
  - If cand reverts to the currently launched value, the sequence still completes and recomputes the identical result.
- EVAL state:
  - a_o/b_o are held constant.
  - If cnt == EVAL_CYC-1: go to CAPTURE. Else cnt <= cnt+1.
- CAPTURE state (one cycle):
  - result_o <= {cout_i, sum_i}, done_o <= 1, op_count_o <= op_count_o + 1 (modulo 2^CNT_W, 255 -> 0 at default width).
  - Go to IDLE.
- done_o is registered and high for exactly the one cycle after CAPTURE; it is cleared on every other cycle.
- busy_o is decoded from the state register: 0 in IDLE, 1 otherwise. It is low on the cycle done_o is high.
- Latency: from the first edge at which op_word_i holds the new value to done_o high = 3 + SETTLE_CYC + EVAL_CYC edges (9 at defaults). Any op_word_i change during SETTLE extends this.
- op_word_i changes during EVAL/CAPTURE:
  - The in-flight operation is unaffected.
  - The new value is detected in IDLE on the following cycle and starts a new sequence.
- result_o holds its last value until the next CAPTURE; it is never cleared except by rst.
- rst asserted mid-operation: abort immediately, no done_o, outputs return to reset values, op_count_o = 0.
- Arithmetic: no width extension inside this block; carry is bit 8 of result_o, taken directly from cout_i.

Test Plan:
- Reset with op_word_i = 0x0000 -> IDLE, busy_o = 0, result_o = 0x000, no done_o within 50 cycles.
- op_word_i = 0x0503 (A=3, B=5), held -> done_o pulses exactly 9 edges later; result_o = 0x008; op_count_o = 1; a_o = 0x03, b_o = 0x05.
- op_word_i = 0xFFFF -> result_o = 0x1FE. Then 0x0180 (A=0x80, B=0x01) -> result_o = 0x081. op_count_o increments once per operation.
- Glitchy write: 0x0001 for 2 cycles, then 0x0202 held -> exactly one done_o; result_o = 0x004; op_count_o increments by 1 only.
- Rewrite 0x0202 while idle -> no done_o, busy_o stays 0. Run 256 distinct operations -> op_count_o wraps to 0.
- rst asserted during EVAL -> no done_o; next cycle a_o = b_o = 0, result_o = 0, op_count_o = 0. Operand 0x0101 applied after release -> result_o = 0x002.
